// File: rtl/hack_pkg.sv
// Shared types, instruction field positions and jump decode for the Hack multi-cycle core.
package hack_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM_WR = 2'd2
    } state_t;

    // C_BIT is the 16-bit position; the core uses WIDTH-1 so wider words still work.
    localparam int C_BIT    = 15;
    localparam int A_BIT    = 12;
    localparam int COMP_LSB = 6;
    localparam int D1       = 5;
    localparam int D2       = 4;
    localparam int D3       = 3;
    localparam int J_LSB    = 0;

    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zero/negate each operand, add or AND, optionally negate the result.
module hack_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] x1, x2, y1, y2, o1;

    always_comb begin
        x1  = zx ? '0 : x;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? '0 : y;
        y2  = ny ? ~y1 : y1;
        o1  = f ? (x2 + y2) : (x2 & y2);
        out = no ? ~o1 : o1;
        zr  = (out == '0);
        ng  = out[WIDTH-1];
    end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with ready/valid instruction fetch and data memory handshakes.
// Define HACK_CPU_PERF_EN to add the cycle_cnt / instret performance counters.
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  instr,
    input  logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic [WIDTH-1:0]  inM,
    output logic              readM,
    output logic              writeM,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] addressM,
    output logic [WIDTH-1:0]  outM
`ifdef HACK_CPU_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret
`endif
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ir_q, ir_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  dreg_q, dreg_d;
    logic [WIDTH-1:0]  outm_q, outm_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              readm_q, readm_d;
    logic              writem_q, writem_d;

    logic [WIDTH-1:0]  alu_y, alu_out;
    logic              alu_zr, alu_ng;
    logic [WIDTH-1:0]  res;
    logic              res_zr, res_ng;
    logic              commit, retire;
    logic [ADDR_W-1:0] pc_inc;

    assign alu_y  = ir_q[A_BIT] ? inM : a_q;
    assign pc_inc = pc_q + ADDR_W'(1);

    hack_alu #(.WIDTH(WIDTH)) u_alu (
        .x   (dreg_q),
        .y   (alu_y),
        .zx  (ir_q[COMP_LSB+5]),
        .nx  (ir_q[COMP_LSB+4]),
        .zy  (ir_q[COMP_LSB+3]),
        .ny  (ir_q[COMP_LSB+2]),
        .f   (ir_q[COMP_LSB+1]),
        .no  (ir_q[COMP_LSB]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        a_d      = a_q;
        dreg_d   = dreg_q;
        pc_d     = pc_q;
        outm_d   = outm_q;
        readm_d  = readm_q;
        writem_d = writem_q;
        commit   = 1'b0;
        retire   = 1'b0;
        res      = alu_out;
        res_zr   = alu_zr;
        res_ng   = alu_ng;

        case (state_q)
            FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    readm_d = instr[WIDTH-1] & instr[A_BIT];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!ir_q[WIDTH-1]) begin
                    a_d     = {1'b0, ir_q[WIDTH-2:0]};
                    pc_d    = pc_inc;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (!ir_q[A_BIT] || mem_ready) begin
                    readm_d = 1'b0;
                    if (ir_q[D3]) begin
                        outm_d   = alu_out;
                        writem_d = 1'b1;
                        state_d  = MEM_WR;
                    end else begin
                        commit  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            MEM_WR: begin
                // inM may have moved on; the latched outM is the instruction's result.
                res    = outm_q;
                res_zr = (outm_q == '0);
                res_ng = outm_q[WIDTH-1];
                if (mem_ready) begin
                    writem_d = 1'b0;
                    commit   = 1'b1;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (commit) begin
            retire = 1'b1;
            if (ir_q[D1]) a_d    = res;
            if (ir_q[D2]) dreg_d = res;
            pc_d = jump_taken(ir_q[J_LSB +: 3], res_zr, res_ng) ? a_q[ADDR_W-1:0] : pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            ir_q     <= '0;
            a_q      <= '0;
            dreg_q   <= '0;
            pc_q     <= '0;
            outm_q   <= '0;
            readm_q  <= 1'b0;
            writem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            dreg_q   <= dreg_d;
            pc_q     <= pc_d;
            outm_q   <= outm_d;
            readm_q  <= readm_d;
            writem_q <= writem_d;
        end
    end

    assign pc       = pc_q;
    assign addressM = a_q[ADDR_W-1:0];
    assign outM     = outm_q;
    assign readM    = readm_q;
    assign writeM   = writem_q;

`ifdef HACK_CPU_PERF_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        instret_d = instret_q + {31'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Self-checking bench for hack_cpu_mc against an instruction-level Hack reference model.
module tb_hack_cpu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [14:0] pc;
    logic [15:0] inM = '0;
    logic        readM, writeM;
    logic        mem_ready = 1'b0;
    logic [14:0] addressM;
    logic [15:0] outM;
`ifdef HACK_CPU_PERF_EN
    logic [31:0] cycle_cnt, instret;
`endif

    hack_cpu_mc #(.WIDTH(16), .ADDR_W(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .inM         (inM),
        .readM       (readM),
        .writeM      (writeM),
        .mem_ready   (mem_ready),
        .addressM    (addressM),
        .outM        (outM)
`ifdef HACK_CPU_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret     (instret)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural reference state
    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    int unsigned m_instret;
    int unsigned tb_cyc;

    logic [5:0] comps [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                               6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                               6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    always @(posedge clk) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (readM === 1'b1 && writeM === 1'b1) begin
                n_fail++;
                $display("FAIL rd_wr_exclusive readM=%b writeM=%b required not both high", readM, writeM);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_comp(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return -x;
            6'b110011: return -y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_a = '0;
        m_d = '0;
        m_pc = '0;
        m_instret = 0;
    endtask

    // Drive one instruction through fetch, optional read wait, optional write wait, and check each cycle.
    task automatic exec(input logic [15:0] ins, input logic [15:0] inm, input int rw, input int ww);
        logic        is_c, use_m, wr, neg, zero, pos, jmp;
        logic [15:0] y, r;
        logic [14:0] npc;
        is_c  = ins[15];
        use_m = is_c & ins[12];
        wr    = is_c & ins[3];

        n_checks++;
        if (pc !== m_pc || addressM !== m_a[14:0] || readM !== 1'b0 || writeM !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_state ins=%h pc=%h req %h addr=%h req %h rd=%b wr=%b req 0/0",
                     ins, pc, m_pc, addressM, m_a[14:0], readM, writeM);
        end
        instr = ins;
        instr_valid = 1'b1;
        mem_ready = 1'($urandom);
        inM = 16'($urandom);
        step();
        instr_valid = 1'b0;
        instr = 16'($urandom);

        y = use_m ? inm : m_a;
        r = ref_comp(ins[11:6], m_d, y);

        if (use_m) begin
            for (int k = 0; k <= rw; k++) begin
                n_checks++;
                if (readM !== 1'b1 || writeM !== 1'b0 || addressM !== m_a[14:0]) begin
                    n_fail++;
                    $display("FAIL read_phase ins=%h k=%0d rd=%b wr=%b addr=%h req rd=1 wr=0 addr=%h",
                             ins, k, readM, writeM, addressM, m_a[14:0]);
                end
                mem_ready = (k == rw);
                inM = (k == rw) ? inm : 16'($urandom);
                step();
            end
        end else begin
            n_checks++;
            if (readM !== 1'b0 || writeM !== 1'b0) begin
                n_fail++;
                $display("FAIL exec_no_req ins=%h rd=%b wr=%b req 0/0", ins, readM, writeM);
            end
            mem_ready = 1'($urandom);
            inM = 16'($urandom);
            step();
        end
        mem_ready = 1'b0;

        if (wr) begin
            for (int k = 0; k <= ww; k++) begin
                n_checks++;
                if (writeM !== 1'b1 || readM !== 1'b0 || outM !== r || addressM !== m_a[14:0]) begin
                    n_fail++;
                    $display("FAIL write_phase ins=%h k=%0d wr=%b rd=%b outM=%h addr=%h req wr=1 rd=0 outM=%h addr=%h",
                             ins, k, writeM, readM, outM, addressM, r, m_a[14:0]);
                end
                mem_ready = (k == ww);
                inM = 16'($urandom);
                step();
            end
            mem_ready = 1'b0;
        end

        if (!is_c) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = m_pc + 15'd1;
        end else begin
            neg  = ($signed(r) < 0);
            zero = (r == 16'd0);
            pos  = !neg && !zero;
            jmp  = (ins[2] && neg) || (ins[1] && zero) || (ins[0] && pos);
            npc  = jmp ? m_a[14:0] : (m_pc + 15'd1);
            if (ins[5]) m_a = r;
            if (ins[4]) m_d = r;
            m_pc = npc;
        end
        m_instret++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'($urandom);
        instr = 16'($urandom);
        mem_ready = 1'($urandom);
        step();
        step();
        n_checks++;
        if (pc !== 15'd0 || readM !== 1'b0 || writeM !== 1'b0 || outM !== 16'd0 || addressM !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs pc=%h rd=%b wr=%b outM=%h addr=%h req all zero", pc, readM, writeM, outM, addressM);
        end
        rst = 1'b0;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        model_reset();
        exec(16'h0007, 16'h0, 0, 0);
        exec(16'hEC10, 16'h0, 0, 0);
        n_checks++;
        if (pc !== 15'd2 || addressM !== 15'd7) begin
            n_fail++;
            $display("FAIL reset_first_prog pc=%h addr=%h req pc=0002 addr=0007", pc, addressM);
        end
    endtask

    task automatic test_write_wait();
        logic [14:0] p0;
        p0 = pc;
        exec(16'hE308, 16'h0, 0, 3);
        n_checks++;
        if (pc !== p0 + 15'd1) begin
            n_fail++;
            $display("FAIL write_wait_pc pc=%h req %h", pc, p0 + 15'd1);
        end
    endtask

    task automatic test_read_modify_write();
        exec(16'hFDC8, 16'h0041, 0, 0);
        exec(16'hFDC8, 16'h1234, 2, 1);
    endtask

    task automatic test_jumps();
        logic [14:0] p0;
        exec(16'hEE90, 16'h0, 0, 0);
        exec(16'h0010, 16'h0, 0, 0);
        exec(16'hE304, 16'h0, 0, 0);
        n_checks++;
        if (pc !== 15'h0010) begin
            n_fail++;
            $display("FAIL jlt_taken pc=%h req 0010", pc);
        end
        exec(16'hEE90, 16'h0, 0, 0);
        exec(16'h0010, 16'h0, 0, 0);
        p0 = pc;
        exec(16'hE301, 16'h0, 0, 0);
        n_checks++;
        if (pc !== p0 + 15'd1) begin
            n_fail++;
            $display("FAIL jgt_not_taken pc=%h req %h", pc, p0 + 15'd1);
        end
    endtask

    task automatic test_pc_wrap();
        logic [14:0] p0, a0;
        exec(16'h7FFF, 16'h0, 0, 0);
        exec(16'hEA87, 16'h0, 0, 0);
        n_checks++;
        if (pc !== 15'h7FFF) begin
            n_fail++;
            $display("FAIL jmp_to_top pc=%h req 7fff", pc);
        end
        exec(16'hEC10, 16'h0, 0, 0);
        n_checks++;
        if (pc !== 15'h0000) begin
            n_fail++;
            $display("FAIL pc_wrap pc=%h req 0000", pc);
        end
        p0 = pc;
        a0 = addressM;
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b0;
            instr = 16'($urandom);
            mem_ready = 1'($urandom);
            step();
            n_checks++;
            if (pc !== p0 || addressM !== a0 || readM !== 1'b0 || writeM !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold cyc=%0d pc=%h addr=%h rd=%b wr=%b req pc=%h addr=%h rd=0 wr=0",
                         i, pc, addressM, readM, writeM, p0, a0);
            end
        end
        mem_ready = 1'b0;
        exec(16'hE308, 16'h0, 1, 0);
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 99) < 35)
                ins = {1'b0, 15'($urandom)};
            else
                ins = {3'b111, 1'($urandom), comps[$urandom_range(0, 17)], 3'($urandom), 3'($urandom)};
            exec(ins, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
`ifdef HACK_CPU_PERF_EN
        n_checks++;
        if (instret !== m_instret || cycle_cnt !== tb_cyc) begin
            n_fail++;
            $display("FAIL perf_counts instret=%0d cycle_cnt=%0d req %0d %0d", instret, cycle_cnt, m_instret, tb_cyc);
        end
`endif
    endtask

    task automatic test_reset_in_memwr();
        exec(16'h0123, 16'h0, 0, 0);
        exec(16'hEE90, 16'h0, 0, 0);
        instr = 16'hE7F8;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        step();
        n_checks++;
        if (writeM !== 1'b1) begin
            n_fail++;
            $display("FAIL memwr_entered wr=%b req 1", writeM);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (writeM !== 1'b0 || readM !== 1'b0 || pc !== 15'd0 || addressM !== 15'd0 || outM !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_in_memwr wr=%b rd=%b pc=%h addr=%h outM=%h req all zero", writeM, readM, pc, addressM, outM);
        end
`ifdef HACK_CPU_PERF_EN
        n_checks++;
        if (cycle_cnt !== 32'd0 || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset cycle_cnt=%0d instret=%0d req 0 0", cycle_cnt, instret);
        end
`endif
        model_reset();
        exec(16'hE308, 16'h0, 0, 2);
        exec(16'hFDC8, 16'h0FFF, 1, 0);
    endtask

    initial begin
        test_reset();
        test_write_wait();
        test_read_modify_write();
        test_jumps();
        test_pc_wrap();
        test_random();
        test_reset_in_memwr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
